// File: rtl/control_seq.sv
// Microcoded control sequencer for the 8-bit datapath: fetches, decodes and steps opcodes.
// Define CONTROL_SEQ_TRAP_EN to trap illegal opcodes into HALT with a sticky illegal flag.
module control_seq #(
    parameter int unsigned WIDTH_MAIN = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_MAIN-1:0] mem_in,
    input  logic                  flag_zero,
    output logic [3:0]            gp_assert_main,
    output logic [3:0]            gp_load_main,
    output logic [3:0]            gp_assert_lhs,
    output logic [3:0]            gp_assert_rhs,
    output logic                  const_load_mem,
    output logic                  const_assert_main,
    output logic                  mem_dir,
    output logic                  mem_assert_main,
    output logic                  alu_assert_main,
    output logic [3:0]            alu_operation,
    output logic                  xfer_loadlow_main,
    output logic                  xfer_loadhigh_main,
    output logic                  xfer_assert_xfer,
    output logic                  pcra0_assert_addr,
    output logic                  pcra0_inc,
    output logic                  pcra0_load_xfer,
    output logic                  halted,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StImmWr,
        StJhi,
        StJld,
        StHalt
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH_MAIN-1:0] ir_q, ir_d;
    logic                  zf_q, zf_d;
    logic                  illegal_q, illegal_d;

    logic is_nop, is_hlt, is_jmp, is_jz, is_mov, is_ldi, is_alu;

    always_comb begin
        is_nop = (ir_q == 8'h00);
        is_hlt = (ir_q == 8'h01);
        is_jmp = (ir_q == 8'h02);
        is_jz  = (ir_q == 8'h03);
        is_mov = (ir_q[7:6] == 2'b01);
        is_ldi = (ir_q[7:6] == 2'b10);
        is_alu = (ir_q[7:4] == 4'b1100);
    end

    always_comb begin
        gp_assert_main     = 4'b0000;
        gp_load_main       = 4'b0000;
        gp_assert_lhs      = 4'b0000;
        gp_assert_rhs      = 4'b0000;
        const_load_mem     = 1'b0;
        const_assert_main  = 1'b0;
        mem_dir            = 1'b0;
        mem_assert_main    = 1'b0;
        alu_assert_main    = 1'b0;
        alu_operation      = 4'b0000;
        xfer_loadlow_main  = 1'b0;
        xfer_loadhigh_main = 1'b0;
        xfer_assert_xfer   = 1'b0;
        pcra0_assert_addr  = 1'b0;
        pcra0_inc          = 1'b0;
        pcra0_load_xfer    = 1'b0;
        state_d            = state_q;
        ir_d               = ir_q;
        zf_d               = zf_q;
        illegal_d          = illegal_q;

        // Reset masks every strobe in the cycle it is asserted; state is reloaded by always_ff.
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    pcra0_assert_addr = 1'b1;
                    pcra0_inc         = 1'b1;
                    ir_d              = mem_in;
                    state_d           = StExec;
                end
                StExec: begin
                    if (is_nop) begin
                        state_d = StFetch;
                    end else if (is_hlt) begin
                        state_d = StHalt;
                    end else if (is_mov) begin
                        gp_assert_main[ir_q[3:2]] = 1'b1;
                        gp_load_main[ir_q[5:4]]   = 1'b1;
                        state_d                   = StFetch;
                    end else if (is_alu) begin
                        gp_assert_lhs[0] = 1'b1;
                        gp_assert_rhs[1] = 1'b1;
                        alu_operation    = ir_q[3:0];
                        alu_assert_main  = 1'b1;
                        gp_load_main[0]  = 1'b1;
                        state_d          = StFetch;
                    end else if (is_ldi) begin
                        pcra0_assert_addr = 1'b1;
                        const_load_mem    = 1'b1;
                        pcra0_inc         = 1'b1;
                        state_d           = StImmWr;
                    end else if (is_jmp || is_jz) begin
                        pcra0_assert_addr = 1'b1;
                        mem_dir           = 1'b1;
                        mem_assert_main   = 1'b1;
                        xfer_loadlow_main = 1'b1;
                        pcra0_inc         = 1'b1;
                        zf_d              = flag_zero;
                        state_d           = StJhi;
                    end else begin
`ifdef CONTROL_SEQ_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = StHalt;
`else
                        state_d   = StFetch;
`endif
                    end
                end
                StImmWr: begin
                    const_assert_main       = 1'b1;
                    gp_load_main[ir_q[5:4]] = 1'b1;
                    state_d                 = StFetch;
                end
                StJhi: begin
                    pcra0_assert_addr  = 1'b1;
                    mem_dir            = 1'b1;
                    mem_assert_main    = 1'b1;
                    xfer_loadhigh_main = 1'b1;
                    pcra0_inc          = 1'b1;
                    // ir[0] distinguishes JZ (0x03) from JMP (0x02).
                    state_d            = (!ir_q[0] || zf_q) ? StJld : StFetch;
                end
                StJld: begin
                    xfer_assert_xfer = 1'b1;
                    pcra0_load_xfer  = 1'b1;
                    state_d          = StFetch;
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            ir_q      <= '0;
            zf_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            zf_q      <= zf_d;
            illegal_q <= illegal_d;
        end
    end

    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: per-cycle expected strobe vectors checked by a monitor,
// with a small datapath model (PC, registers, const, xfer) driven by the DUT strobes.
module tb_control_seq;

    logic        clk;
    logic        reset;
    logic [7:0]  mem_in;
    logic        flag_zero;
    logic [3:0]  gp_assert_main, gp_load_main, gp_assert_lhs, gp_assert_rhs;
    logic        const_load_mem, const_assert_main, mem_dir, mem_assert_main;
    logic        alu_assert_main;
    logic [3:0]  alu_operation;
    logic        xfer_loadlow_main, xfer_loadhigh_main, xfer_assert_xfer;
    logic        pcra0_assert_addr, pcra0_inc, pcra0_load_xfer;
    logic        halted, illegal;

    control_seq #(.WIDTH_MAIN(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_in             (mem_in),
        .flag_zero          (flag_zero),
        .gp_assert_main     (gp_assert_main),
        .gp_load_main       (gp_load_main),
        .gp_assert_lhs      (gp_assert_lhs),
        .gp_assert_rhs      (gp_assert_rhs),
        .const_load_mem     (const_load_mem),
        .const_assert_main  (const_assert_main),
        .mem_dir            (mem_dir),
        .mem_assert_main    (mem_assert_main),
        .alu_assert_main    (alu_assert_main),
        .alu_operation      (alu_operation),
        .xfer_loadlow_main  (xfer_loadlow_main),
        .xfer_loadhigh_main (xfer_loadhigh_main),
        .xfer_assert_xfer   (xfer_assert_xfer),
        .pcra0_assert_addr  (pcra0_assert_addr),
        .pcra0_inc          (pcra0_inc),
        .pcra0_load_xfer    (pcra0_load_xfer),
        .halted             (halted),
        .illegal            (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector layout (LSB first): illegal, halted, pc_load, pc_inc, pc_addr, xfer_assert,
    // xfer_hi, xfer_lo, alu_op[3:0], alu_assert, mem_assert, mem_dir, const_assert, const_load,
    // gp_rhs[3:0], gp_lhs[3:0], gp_load[3:0], gp_assert[3:0].
    localparam logic [32:0] IL = 33'd1 << 0;
    localparam logic [32:0] HA = 33'd1 << 1;
    localparam logic [32:0] PL = 33'd1 << 2;
    localparam logic [32:0] PI = 33'd1 << 3;
    localparam logic [32:0] PA = 33'd1 << 4;
    localparam logic [32:0] XA = 33'd1 << 5;
    localparam logic [32:0] XH = 33'd1 << 6;
    localparam logic [32:0] XL = 33'd1 << 7;
    localparam logic [32:0] AA = 33'd1 << 12;
    localparam logic [32:0] MA = 33'd1 << 13;
    localparam logic [32:0] MD = 33'd1 << 14;
    localparam logic [32:0] CA = 33'd1 << 15;
    localparam logic [32:0] CL = 33'd1 << 16;
    localparam logic [32:0] F    = PA | PI;
    localparam logic [32:0] JLO  = PA | MD | MA | XL | PI;
    localparam logic [32:0] JHI  = PA | MD | MA | XH | PI;
    localparam logic [32:0] JLD  = XA | PL;
    localparam logic [32:0] NONE = 33'd0;

    function automatic logic [32:0] aop(input logic [3:0] v);
        return {21'd0, v, 8'd0};
    endfunction
    function automatic logic [32:0] grhs(input logic [3:0] v);
        return {12'd0, v, 17'd0};
    endfunction
    function automatic logic [32:0] glhs(input logic [3:0] v);
        return {8'd0, v, 21'd0};
    endfunction
    function automatic logic [32:0] gld(input logic [3:0] v);
        return {4'd0, v, 25'd0};
    endfunction
    function automatic logic [32:0] gam(input logic [3:0] v);
        return {v, 29'd0};
    endfunction

    logic [32:0] obs;
    assign obs = {gp_assert_main, gp_load_main, gp_assert_lhs, gp_assert_rhs,
                  const_load_mem, const_assert_main, mem_dir, mem_assert_main,
                  alu_assert_main, alu_operation,
                  xfer_loadlow_main, xfer_loadhigh_main, xfer_assert_xfer,
                  pcra0_assert_addr, pcra0_inc, pcra0_load_xfer, halted, illegal};

    // Datapath model
    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic [15:0] xfer;
    logic [7:0]  cst;
    logic [7:0]  gp [4];
    logic [7:0]  bus;
    int          inc_cnt;
    logic        fz_sel;

    assign mem_in = pcra0_assert_addr ? mem[pc] : 8'h00;
    // Only the EXEC-cycle value should matter, so the flag is inverted in every other cycle.
    assign flag_zero = xfer_loadlow_main ? fz_sel : ~fz_sel;

    always_comb begin
        bus = 8'h00;
        if (mem_assert_main) bus = mem_in;
        if (const_assert_main) bus = cst;
        if (alu_assert_main) bus = gp[0] + gp[1];
        for (int i = 0; i < 4; i++) if (gp_assert_main[i]) bus = gp[i];
    end

    always @(posedge clk) begin
        if (reset) begin
            pc      <= 16'h0000;
            xfer    <= 16'h0000;
            cst     <= 8'h00;
            inc_cnt <= 0;
            for (int i = 0; i < 4; i++) gp[i] <= 8'h00;
        end else begin
            if (pcra0_load_xfer) pc <= xfer;
            else if (pcra0_inc) pc <= pc + 16'd1;
            if (pcra0_inc) inc_cnt <= inc_cnt + 1;
            if (const_load_mem) cst <= mem_in;
            if (xfer_loadlow_main) xfer[7:0] <= bus;
            if (xfer_loadhigh_main) xfer[15:8] <= bus;
            for (int i = 0; i < 4; i++) if (gp_load_main[i]) gp[i] <= bus;
        end
    end

    // Scoreboard
    logic [32:0] exp_q[$];
    int          nchecks;
    int          nerr;
    int          cyc_idx;
    string       test_name;

    initial begin
        int          drv;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            drv = $countones(gp_assert_main) + int'(mem_assert_main) + int'(const_assert_main)
                + int'(alu_assert_main);
            nchecks++;
            if (drv > 1 || mem_dir !== mem_assert_main) begin
                nerr++;
                $display("FAIL %s bus_invariant: drivers=%0d mem_dir=%b mem_assert=%b (need <=1, equal)",
                         test_name, drv, mem_dir, mem_assert_main);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                nchecks++;
                if (obs !== e) begin
                    nerr++;
                    $display("FAIL %s strobes cycle %0d: got %h expected %h",
                             test_name, cyc_idx, obs, e);
                end
                cyc_idx++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s %s: got %h expected %h", test_name, name, act, expv);
        end
    endtask

    task automatic push(input logic [32:0] v);
        exp_q.push_back(v);
    endtask

    task automatic start(input string name);
        test_name = name;
        cyc_idx   = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        nchecks++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL %s drain: %0d expected cycles left, need 0", test_name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 8; i++) mem[i] = 8'h01;
    endtask

    initial begin
        nchecks = 0;
        nerr    = 0;
        reset   = 1'b1;
        fz_sel  = 1'b0;
        test_name = "init";
        cyc_idx = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h01;

        // LDI B,0x5A
        mem[0] = 8'h90; mem[1] = 8'h5A;
        start("ldi");
        push(F); push(PA | PI | CL); push(CA | gld(4'b0010)); push(F); push(NONE);
        push(HA); push(HA);
        drain();
        check("reg_b", 32'(gp[1]), 32'h5A);
        check("pc", 32'(pc), 32'h3);
        clear_prog();

        // LDI A,0x77 ; MOV C<-A
        mem[0] = 8'h80; mem[1] = 8'h77; mem[2] = 8'h60;
        start("mov");
        push(F); push(PA | PI | CL); push(CA | gld(4'b0001));
        push(F); push(gam(4'b0001) | gld(4'b0100)); push(F); push(NONE); push(HA);
        drain();
        check("reg_c", 32'(gp[2]), 32'h77);
        check("pc", 32'(pc), 32'h4);
        clear_prog();

        // ALU op 5
        mem[0] = 8'hC5;
        start("alu");
        push(F); push(glhs(4'b0001) | grhs(4'b0010) | aop(4'd5) | AA | gld(4'b0001));
        push(F); push(NONE); push(HA);
        drain();
        check("pc", 32'(pc), 32'h2);
        clear_prog();

        // JMP 0x1234
        mem[0] = 8'h02; mem[1] = 8'h34; mem[2] = 8'h12;
        start("jmp");
        push(F); push(JLO); push(JHI); push(JLD); push(F); push(NONE); push(HA);
        drain();
        check("xfer", 32'(xfer), 32'h1234);
        check("pc", 32'(pc), 32'h1235);
        check("inc_pulses", 32'(inc_cnt), 32'd4);

        // JZ 0x2000 not taken
        mem[0] = 8'h03; mem[1] = 8'h00; mem[2] = 8'h20;
        fz_sel = 1'b0;
        start("jz_nt");
        push(F); push(JLO); push(JHI); push(F); push(NONE); push(HA);
        drain();
        check("pc", 32'(pc), 32'h4);
        check("inc_pulses", 32'(inc_cnt), 32'd4);

        // JZ 0x2000 taken
        fz_sel = 1'b1;
        start("jz_t");
        push(F); push(JLO); push(JHI); push(JLD); push(F); push(NONE); push(HA);
        drain();
        check("pc", 32'(pc), 32'h2001);
        fz_sel = 1'b0;
        clear_prog();

        // HLT holds with no strobes
        start("hlt");
        push(F); push(NONE);
        for (int i = 0; i < 20; i++) push(HA);
        drain();
        check("pc", 32'(pc), 32'h1);

        // Illegal opcode
        mem[0] = 8'hFF;
        start("illegal");
`ifdef CONTROL_SEQ_TRAP_EN
        push(F); push(NONE); push(HA | IL); push(HA | IL); push(HA | IL);
        drain();
        check("pc", 32'(pc), 32'h1);
`else
        push(F); push(NONE); push(F); push(NONE); push(HA); push(HA);
        drain();
        check("pc", 32'(pc), 32'h2);
`endif
        clear_prog();

        // Reset during JHI, then the JMP reruns cleanly
        mem[0] = 8'h02; mem[1] = 8'h34; mem[2] = 8'h12;
        start("reset_jhi");
        push(F); push(JLO); push(NONE);
        push(F); push(JLO); push(JHI); push(JLD); push(F); push(NONE); push(HA);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drain();
        check("pc", 32'(pc), 32'h1235);
        check("inc_pulses", 32'(inc_cnt), 32'd4);
        clear_prog();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/control_seq.md
# control_seq

Microcoded control sequencer that drives the register, memory, ALU and bus-steering strobes of the 8-bit datapath. It fetches opcode bytes via the PC register (pcra0) and the memory bus, decodes a small instruction set, and steps through one-cycle micro-steps. Each micro-step asserts exactly the strobes that step requires. It sits beside the core datapath, consumes its `mem_out` and `flag_zero`, and replaces the testbench as the source of control inputs.

## Interface
Parameters:
- `WIDTH_MAIN`, 8: main/mem bus width; the opcode width.

Ports:
- `clk` in 1: sole clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_in` in 8: memory bus value at the address on the addr bus.
- `flag_zero` in 1: ALU zero flag.
- `gp_assert_main`, `gp_load_main`, `gp_assert_lhs`, `gp_assert_rhs` out 4 each: register strobes; bit0=A, bit1=B, bit2=C, bit3=D.
- `const_load_mem`, `const_assert_main` out 1: const register strobes.
- `mem_dir`, `mem_assert_main` out 1: memory direction (1 = mem->main) and main-bus drive.
- `alu_assert_main` out 1; `alu_operation` out 4.
- `xfer_loadlow_main`, `xfer_loadhigh_main`, `xfer_assert_xfer` out 1: xfer register strobes.
- `pcra0_assert_addr`, `pcra0_inc`, `pcra0_load_xfer` out 1: PC strobes.
- `halted` out 1: sequencer in HALT.
- `illegal` out 1: sticky illegal-opcode indicator.

## Operation
- Instruction register `ir` (8 bits); state register over FETCH, EXEC, IMM_WR, JHI, JLD, HALT.
- Encodings: 0x00 NOP; 0x01 HLT; 0x02 JMP lo,hi; 0x03 JZ lo,hi; `01ddss__` MOV d<-s; `10dd____` LDI d,imm8; `1100oooo` ALU op o, A <- f(A,B); all others illegal (0x04–0x3F, 0xD0–0xFF).
- FETCH: `pcra0_assert_addr`, `pcra0_inc`. At the edge: `ir` <- `mem_in`, go to EXEC.
- EXEC by `ir`:
  - NOP: no strobes, -> FETCH.
  - HLT: no strobes, -> HALT.
  - MOV: `gp_assert_main[s]`, `gp_load_main[d]`, -> FETCH. d==s is legal and has no effect.
  - ALU: `gp_assert_lhs[0]`, `gp_assert_rhs[1]`, `alu_operation`=o, `alu_assert_main`, `gp_load_main[0]`, -> FETCH.
  - LDI: `pcra0_assert_addr`, `const_load_mem`, `pcra0_inc`, -> IMM_WR.
  - JMP/JZ: `pcra0_assert_addr`, `mem_dir`, `mem_assert_main`, `xfer_loadlow_main`, `pcra0_inc`; latch `zf_q` <- `flag_zero`; -> JHI.
- IMM_WR: `const_assert_main`, `gp_load_main[d]`, -> FETCH.
- JHI: as the JMP/JZ EXEC step but with `xfer_loadhigh_main`. -> JLD if JMP, or if JZ and `zf_q`=1; otherwise -> FETCH.
- JLD: `xfer_assert_xfer`, `pcra0_load_xfer`, -> FETCH.
- HALT: no strobes; left only by `reset`.
- `mem_dir` is 1 in every cycle where `mem_assert_main` is 1; otherwise 0.

## Timing
- All strobes are combinational decodes of state and `ir` (Moore). The datapath acts on the rising edge that ends the step.
- Cycles per instruction, FETCH included: NOP 2, HLT 2, MOV 2, ALU 2, LDI 3, JMP 4, JZ taken 4, JZ not taken 3.
- `pcra0_inc` pulses once per instruction byte consumed, so JZ not taken still skips both operand bytes.
- `reset`=1: every strobe forced 0 that cycle. The next state is FETCH, with `ir`=0x00, `zf_q`=0, `halted`=0, `illegal`=0. Reset mid-instruction abandons it, with no partial strobe after the reset edge.
- The `flag_zero` value used by JZ is the one present during its EXEC cycle.
- At most one register drives main in any cycle; the bench checks this invariant every cycle.

## Configuration
- `CONTROL_SEQ_TRAP_EN` defined: an illegal opcode in EXEC sets `illegal`=1 and goes to HALT, with no strobes.
- Undefined: an illegal opcode executes as NOP (2 cycles) and `illegal` stays 0.

## Test plan
- Reset, then memory 0x90,0x5A: cycle 1 FETCH (`pcra0_inc`=1); cycle 2 `const_load_mem`=1; cycle 3 `const_assert_main`=1 and `gp_load_main`=4'b0010; B=0x5A; PC advanced by 2.
- Opcode 0x60 (MOV C<-A): EXEC `gp_assert_main`=4'b0001, `gp_load_main`=4'b0100; next FETCH on cycle 3.
- Opcode 0xC5: EXEC `gp_assert_lhs`=0001, `gp_assert_rhs`=0010, `alu_operation`=5, `alu_assert_main`=1, `gp_load_main`=0001.
- JMP bytes 0x02,0x34,0x12 at 0x0000: `xfer_loadlow_main` then `xfer_loadhigh_main`, then `pcra0_load_xfer`; next FETCH address 0x1234; 3 `pcra0_inc` pulses total.
- JZ 0x03,0x00,0x20 with `flag_zero`=0: 3 cycles, no `pcra0_load_xfer`, PC=3. Repeated with `flag_zero`=1: 4 cycles, PC=0x2000.
- Opcode 0x01 gives `halted`=1 and all strobes 0 for 20 cycles. Opcode 0xFF with the macro gives `illegal`=1, halted; without the macro it executes as NOP. `reset` during JHI gives all strobes 0 on that cycle, then FETCH.
